check_queue_instr_mux: RTL and testbench
========================================

Name: check_queue_instr_mux

Overview:
- Fetch-stage instruction source selector for the superscalar MIPS front end.
- Picks the next instruction word from the instruction queue when mx_i_check_queue=1, otherwise from instruction memory.
- Generates source-side consume strobes and a registered valid/last-source status.
- Keeps saturating per-source select counters for performance monitoring.

Parameters:
- IWIDTH, 32 (value of the global `IWIDTH define), instruction word width.
- CNT_W, 16, width of each select counter.
- NOP_WORD, 32'h0000_0000, value driven on the instruction output when nothing valid is selected and while in reset (registered mode).

Ports:
- mx_clk  input  1  rising-edge clock
- mx_rst  input  1  synchronous, active-high reset
- mx_i_check_queue  input  1  1 = select queue, 0 = select memory
- mx_i_queue_instr  input  IWIDTH  instruction from the queue
- mx_i_queue_valid  input  1  queue word valid
- mx_i_mem_instr  input  IWIDTH  instruction from memory
- mx_i_mem_valid  input  1  memory word valid
- mx_i_stall  input  1  downstream stall; blocks consumption
- mx_o_instr  output  IWIDTH  selected instruction
- mx_o_valid  output  1  selected source valid
- mx_o_queue_pop  output  1  one-cycle queue consume strobe
- mx_o_mem_ack  output  1  one-cycle memory consume strobe
- mx_o_last_src  output  1  registered source of the last consumed word (1 = queue)
- mx_o_queue_cnt  output  CNT_W  count of consumed queue words
- mx_o_mem_cnt  output  CNT_W  count of consumed memory words

Behaviour:
- Data path is combinational, zero latency:
  - mx_o_instr = mx_i_check_queue ? mx_i_queue_instr : mx_i_mem_instr.
  - mx_o_instr does not depend on the valid inputs, stall, clock or reset.
- mx_o_valid = mx_i_check_queue ? mx_i_queue_valid : mx_i_mem_valid (combinational).
- Consume strobes (combinational, mutually exclusive):
  - mx_o_queue_pop = check_queue & queue_valid & ~stall.
  - mx_o_mem_ack = ~check_queue & mem_valid & ~stall.
- The unselected source is never consumed, even when it is valid.
- Registered state updates on the rising edge of mx_clk:
  - On queue_pop: mx_o_queue_cnt increments and mx_o_last_src <= 1.
  - On mem_ack: mx_o_mem_cnt increments and mx_o_last_src <= 0.
  - Counters saturate at all-ones and never wrap.
  - With no consume, all state holds.
- Stall has priority: stall=1 suppresses both strobes, so counters and last_src hold.
- Reset (mx_rst=1 at a clock edge):
  - Both counters <= 0 and mx_o_last_src <= 0.
  - Reset takes priority over a simultaneous consume.
  - Combinational outputs remain live during reset.
- A select change mid-stream takes effect in the same cycle; there is no hysteresis.

Optional Feature:
- Macro: MUX_OUT_REG_EN.
- Defined:
  - mx_o_instr and mx_o_valid come from a pipeline register, giving 1 cycle of latency.
  - On a consume, the register loads the selected word and sets valid=1.
  - On stall, the register holds its contents.
  - Otherwise the register loads NOP_WORD with valid=0.
  - Reset loads NOP_WORD and valid=0.
  - Strobes and counters are unchanged.
- Undefined: purely combinational data path as described above.

Decomposition:
- Shared package/header holds the IWIDTH define, NOP_WORD constant, and the source encoding (SRC_MEM=0, SRC_QUEUE=1).
- One natural sub-module: sat_counter (CNT_W-wide, sync reset, inc input, saturating), instantiated twice.

Test Plan:
- check_queue=1, queue_instr=32'hcafecafe, mem_instr=32'hfafafafa -> mx_o_instr=cafecafe. Then check_queue=0 -> mx_o_instr=fafafafa in the same delta, with no clock edge needed.
- check_queue=1, queue_valid=1, stall=0 for 3 clocks -> queue_pop high each cycle, queue_cnt=3, mem_cnt=0, last_src=1.
- check_queue=0, mem_valid=1, queue_valid=1, stall=1 -> both strobes 0, counters hold. Deassert stall -> mem_ack=1, mem_cnt+1, last_src=0.
- Drive mem_cnt to all-ones (CNT_W=4: 15 acks), then one more ack -> mem_cnt stays 4'hF.
- Reset asserted together with a queue consume -> next edge queue_cnt=0 and last_src=0. mx_o_instr still follows the select.
- With MUX_OUT_REG_EN: consume of cafecafe at edge N -> mx_o_instr=cafecafe, valid=1 after edge N. Idle next cycle -> NOP_WORD, valid=0.

Source files
------------

// File: rtl/check_queue_instr_mux_pkg.sv
// ---------------------------------------------------------------------------
// check_queue_instr_mux_pkg
// Shared definitions for the fetch-stage instruction source selector:
//   `IWIDTH      global instruction word width (defaults to 32)
//   NOP_WORD_DEF word presented when nothing valid is held (registered mode)
//   src_e        source encoding: SRC_MEM = 0, SRC_QUEUE = 1
// ---------------------------------------------------------------------------
`ifndef IWIDTH
`define IWIDTH 32
`endif

package check_queue_instr_mux_pkg;

    localparam int IWIDTH_DEF = `IWIDTH;
    localparam logic [`IWIDTH-1:0] NOP_WORD_DEF = '0;

    typedef enum logic {
        SRC_MEM   = 1'b0,
        SRC_QUEUE = 1'b1
    } src_e;

endpackage

// File: rtl/check_queue_instr_mux_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// CNT_W-wide up counter that sticks at all-ones instead of wrapping.
// Ports:
//   i_clk  rising-edge clock
//   i_rst  synchronous active-high reset (clears to 0)
//   i_inc  increment request for this cycle
//   o_cnt  current count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_full;

    assign w_full = &r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_inc && !w_full) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/check_queue_instr_mux.sv
// ---------------------------------------------------------------------------
// check_queue_instr_mux
// Fetch-stage instruction source selector. Chooses the instruction queue
// (mx_i_check_queue=1) or instruction memory (0), emits one-cycle consume
// strobes back to the chosen source, tracks which source was consumed last
// and keeps saturating per-source consume counters.
//
// Optional feature macro: MUX_OUT_REG_EN
//   defined   -> mx_o_instr / mx_o_valid come from a one-cycle output register
//   undefined -> mx_o_instr / mx_o_valid are purely combinational
//
// Ports:
//   mx_clk, mx_rst        clock, synchronous active-high reset
//   mx_i_check_queue      source select (1 = queue, 0 = memory)
//   mx_i_queue_instr/valid  queue word and its valid
//   mx_i_mem_instr/valid    memory word and its valid
//   mx_i_stall            downstream stall, blocks all consumption
//   mx_o_instr/valid      selected word and valid
//   mx_o_queue_pop        queue consume strobe
//   mx_o_mem_ack          memory consume strobe
//   mx_o_last_src         source of last consumed word (1 = queue)
//   mx_o_queue_cnt/mem_cnt  saturating consume counters
// ---------------------------------------------------------------------------
module check_queue_instr_mux
    import check_queue_instr_mux_pkg::*;
#(
    parameter int                IWIDTH   = IWIDTH_DEF,
    parameter int                CNT_W    = 16,
    parameter logic [IWIDTH-1:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic              mx_clk,
    input  logic              mx_rst,
    input  logic              mx_i_check_queue,
    input  logic [IWIDTH-1:0] mx_i_queue_instr,
    input  logic              mx_i_queue_valid,
    input  logic [IWIDTH-1:0] mx_i_mem_instr,
    input  logic              mx_i_mem_valid,
    input  logic              mx_i_stall,
    output logic [IWIDTH-1:0] mx_o_instr,
    output logic              mx_o_valid,
    output logic              mx_o_queue_pop,
    output logic              mx_o_mem_ack,
    output logic              mx_o_last_src,
    output logic [CNT_W-1:0]  mx_o_queue_cnt,
    output logic [CNT_W-1:0]  mx_o_mem_cnt
);

    logic [IWIDTH-1:0] w_sel_instr;
    logic              w_sel_valid;
    logic              w_pop;
    logic              w_ack;
    src_e              r_last_src;

    assign w_sel_instr = mx_i_check_queue ? mx_i_queue_instr : mx_i_mem_instr;
    assign w_sel_valid = mx_i_check_queue ? mx_i_queue_valid : mx_i_mem_valid;

    // Only the selected source can ever be consumed; stall blocks both.
    assign w_pop = mx_i_check_queue  & mx_i_queue_valid & ~mx_i_stall;
    assign w_ack = ~mx_i_check_queue & mx_i_mem_valid   & ~mx_i_stall;

    assign mx_o_queue_pop = w_pop;
    assign mx_o_mem_ack   = w_ack;

    always_ff @(posedge mx_clk) begin
        if (mx_rst) begin
            r_last_src <= SRC_MEM;
        end else if (w_pop) begin
            r_last_src <= SRC_QUEUE;
        end else if (w_ack) begin
            r_last_src <= SRC_MEM;
        end
    end

    assign mx_o_last_src = r_last_src;

    sat_counter #(.CNT_W(CNT_W)) u_queue_cnt (
        .i_clk (mx_clk),
        .i_rst (mx_rst),
        .i_inc (w_pop),
        .o_cnt (mx_o_queue_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_mem_cnt (
        .i_clk (mx_clk),
        .i_rst (mx_rst),
        .i_inc (w_ack),
        .o_cnt (mx_o_mem_cnt)
    );

`ifdef MUX_OUT_REG_EN
    logic [IWIDTH-1:0] r_instr;
    logic              r_valid;

    // Holds only under stall; an idle non-stalled cycle flushes to NOP.
    always_ff @(posedge mx_clk) begin
        if (mx_rst) begin
            r_instr <= NOP_WORD;
            r_valid <= 1'b0;
        end else if (w_pop || w_ack) begin
            r_instr <= w_sel_instr;
            r_valid <= 1'b1;
        end else if (!mx_i_stall) begin
            r_instr <= NOP_WORD;
            r_valid <= 1'b0;
        end
    end

    assign mx_o_instr = r_instr;
    assign mx_o_valid = r_valid;
`else
    assign mx_o_instr = w_sel_instr;
    assign mx_o_valid = w_sel_valid;
`endif

endmodule

// File: tb/tb_check_queue_instr_mux.sv
module tb_check_queue_instr_mux;

    localparam int IW    = 32;
    localparam int CW    = 4;
    localparam logic [IW-1:0] NOP = 32'h0000_0000;

    typedef struct {
        logic [IW-1:0] instr;
        logic          valid;
        logic          pop;
        logic          ack;
        logic          last;
        logic [CW-1:0] qcnt;
        logic [CW-1:0] mcnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          sel;
    logic [IW-1:0] qi, mi;
    logic          qv, mv, stall;
    logic [IW-1:0] o_instr;
    logic          o_valid, o_pop, o_ack, o_last;
    logic [CW-1:0] o_qcnt, o_mcnt;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    // reference state (what the registers should hold right now)
    int            m_qcnt = 0, m_mcnt = 0;
    logic          m_last = 1'b0;
    logic [IW-1:0] m_rinstr = NOP;
    logic          m_rvalid = 1'b0;
    int            max_cnt = (1 << CW) - 1;

    always #5 clk = ~clk;

    check_queue_instr_mux #(.IWIDTH(IW), .CNT_W(CW), .NOP_WORD(NOP)) dut (
        .mx_clk           (clk),
        .mx_rst           (rst),
        .mx_i_check_queue (sel),
        .mx_i_queue_instr (qi),
        .mx_i_queue_valid (qv),
        .mx_i_mem_instr   (mi),
        .mx_i_mem_valid   (mv),
        .mx_i_stall       (stall),
        .mx_o_instr       (o_instr),
        .mx_o_valid       (o_valid),
        .mx_o_queue_pop   (o_pop),
        .mx_o_mem_ack     (o_ack),
        .mx_o_last_src    (o_last),
        .mx_o_queue_cnt   (o_qcnt),
        .mx_o_mem_cnt     (o_mcnt)
    );

    task automatic cmp(input string name, input logic [IW-1:0] act, input logic [IW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares whatever the driver has queued against live outputs.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            while (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                cmp("instr", o_instr, e.instr);
                cmp("valid", IW'(o_valid), IW'(e.valid));
                cmp("queue_pop", IW'(o_pop), IW'(e.pop));
                cmp("mem_ack", IW'(o_ack), IW'(e.ack));
                cmp("last_src", IW'(o_last), IW'(e.last));
                cmp("queue_cnt", IW'(o_qcnt), IW'(e.qcnt));
                cmp("mem_cnt", IW'(o_mcnt), IW'(e.mcnt));
            end
        end
    end

    // Drive one cycle of inputs, queue the expected response, advance the model.
    task automatic step(input logic r, input logic s, input logic [IW-1:0] q,
                        input logic qval, input logic [IW-1:0] m, input logic mval,
                        input logic st);
        exp_t e;
        logic pop, ack;
        @(negedge clk);
        rst = r; sel = s; qi = q; qv = qval; mi = m; mv = mval; stall = st;
        #1;
        pop = s && qval && !st;
        ack = !s && mval && !st;
`ifdef MUX_OUT_REG_EN
        e.instr = m_rinstr;
        e.valid = m_rvalid;
`else
        e.instr = s ? q : m;
        e.valid = s ? qval : mval;
`endif
        e.pop  = pop;
        e.ack  = ack;
        e.last = m_last;
        e.qcnt = CW'(m_qcnt);
        e.mcnt = CW'(m_mcnt);
        sb.push_back(e);
        // state after the coming rising edge
        if (r) begin
            m_qcnt = 0; m_mcnt = 0; m_last = 1'b0;
            m_rinstr = NOP; m_rvalid = 1'b0;
        end else begin
            if (pop) begin
                m_qcnt = (m_qcnt < max_cnt) ? m_qcnt + 1 : m_qcnt;
                m_last = 1'b1;
            end
            if (ack) begin
                m_mcnt = (m_mcnt < max_cnt) ? m_mcnt + 1 : m_mcnt;
                m_last = 1'b0;
            end
            if (pop || ack) begin
                m_rinstr = s ? q : m;
                m_rvalid = 1'b1;
            end else if (!st) begin
                m_rinstr = NOP;
                m_rvalid = 1'b0;
            end
        end
    endtask

    task automatic rand_step(input logic r);
        step(r, 1'($urandom), $urandom, 1'($urandom), $urandom, 1'($urandom),
             ($urandom_range(0, 3) == 0));
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; qi = '0; mi = '0; qv = 1'b0; mv = 1'b0; stall = 1'b0;
        repeat (2) @(posedge clk);

        // reset state, combinational select with valid low
        step(1'b1, 1'b1, 32'hcafecafe, 1'b0, 32'hfafafafa, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'hcafecafe, 1'b0, 32'hfafafafa, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'hcafecafe, 1'b0, 32'hfafafafa, 1'b0, 1'b0);
        // three queue pops
        repeat (3) step(1'b0, 1'b1, 32'hcafecafe, 1'b1, 32'hfafafafa, 1'b0, 1'b0);
        // stalled memory select with both valid, then release
        step(1'b0, 1'b0, 32'h11111111, 1'b1, 32'h22222222, 1'b1, 1'b1);
        step(1'b0, 1'b0, 32'h11111111, 1'b1, 32'h22222222, 1'b1, 1'b0);
        step(1'b0, 1'b1, 32'h33333333, 1'b0, 32'h44444444, 1'b1, 1'b0);
        // random traffic
        repeat (200) rand_step(1'b0);
        // memory saturation: more acks than the counter can hold
        repeat (20) step(1'b0, 1'b0, $urandom, 1'b1, $urandom, 1'b1, 1'b0);
        repeat (20) step(1'b0, 1'b1, $urandom, 1'b1, $urandom, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        // reset together with a queue consume
        step(1'b1, 1'b1, 32'hcafecafe, 1'b1, 32'hfafafafa, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'hcafecafe, 1'b0, 32'hfafafafa, 1'b0, 1'b0);
        // registered-path consume then idle
        step(1'b0, 1'b1, 32'hcafecafe, 1'b1, 32'hfafafafa, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'hcafecafe, 1'b0, 32'hfafafafa, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'hcafecafe, 1'b0, 32'hfafafafa, 1'b0, 1'b0);
        // more random traffic with occasional resets
        repeat (200) rand_step($urandom_range(0, 19) == 0);

        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
